// File: rtl/wb_queue.sv
// wb_queue: ordered register-file write-back queue with hazard probe; define WB_QUEUE_FORWARD_EN to enable data forwarding
module wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_dir,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [4:0]  mem_dir,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        reg_wr,
   output logic [4:0]  dir_wra,
   output logic [31:0] di,
   input  logic [4:0]  fwd_dir,
   output logic        haz_hit,
   output logic        fwd_hit,
   output logic [31:0] fwd_data,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [4:0]    dir_q  [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          full, push, pop;
   logic [4:0]    in_dir;
   logic [31:0]   in_data;
   assign full      = count == CW'(DEPTH);
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;
   assign in_dir    = mem_valid ? mem_dir : alu_dir;
   assign in_data   = mem_valid ? mem_data : alu_data;
   // writes to r0 complete the handshake but are never queued
   assign push      = ((mem_valid && mem_ready) || (alu_valid && alu_ready)) && in_dir != 5'd0;
   assign pop       = count != '0;
   assign busy      = pop || reg_wr;
   // payload storage needs no reset; validity comes from count
   always_ff @(posedge clk) begin
      if (push) begin
         dir_q[wr_ptr]  <= in_dir;
         data_q[wr_ptr] <= in_data;
      end
   end
   // pointers, occupancy and registered write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         reg_wr  <= 1'b0;
         dir_wra <= '0;
         di      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count  <= count + CW'(push) - CW'(pop);
         reg_wr <= pop;
         if (pop) begin
            dir_wra <= dir_q[rd_ptr];
            di      <= data_q[rd_ptr];
         end
      end
   end
   // hazard if the probed address is pending anywhere: queue or output port
   always_comb begin
      haz_hit = fwd_dir != 5'd0 && reg_wr && dir_wra == fwd_dir;
      for (int i = 0; i < DEPTH; i++)
         if (fwd_dir != 5'd0 && i < int'(count) && dir_q[rd_ptr + AW'(i)] == fwd_dir) haz_hit = 1'b1;
   end
`ifdef WB_QUEUE_FORWARD_EN
   // youngest match wins: output port first, then queue entries oldest to newest
   always_comb begin
      fwd_data = (reg_wr && dir_wra == fwd_dir) ? di : '0;
      for (int i = 0; i < DEPTH; i++)
         if (i < int'(count) && dir_q[rd_ptr + AW'(i)] == fwd_dir) fwd_data = data_q[rd_ptr + AW'(i)];
      if (!haz_hit) fwd_data = '0;
   end
   assign fwd_hit = haz_hit;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending write-back entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports alu_valid input 1, alu_dir input 5, alu_data input 32: ALU result write request.
REQ-005 SHALL have port alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-006 SHALL have ports mem_valid input 1, mem_dir input 5, mem_data input 32: load-result write request.
REQ-007 SHALL have port mem_ready  output  1  load request accepted this cycle when high with mem_valid.
REQ-008 SHALL have ports reg_wr output 1, dir_wra output 5, di output 32: register-file write port, registered.
REQ-009 SHALL have port fwd_dir  input  5  operand address probed for pending writes.
REQ-010 SHALL have ports haz_hit output 1, fwd_hit output 1, fwd_data output 32: probe results, combinational.
REQ-011 SHALL have port busy  output  1  high while any write is queued or on the output port.

Function
REQ-012 SHALL hold requests in a DEPTH-entry circular FIFO with read pointer, write pointer and occupancy count 0..DEPTH.
REQ-013 SHALL accept at most one request per cycle; mem has priority: mem_ready = !full; alu_ready = !full && !mem_valid.
REQ-014 SHALL complete a handshake, without storing it, for any accepted request whose address is 0.
REQ-015 SHALL, at each posedge with count>0, pop the head into dir_wra/di and set reg_wr=1; with count==0, set reg_wr=0 and hold dir_wra/di.
REQ-016 SHALL give latency of exactly two posedges from acceptance into an empty queue to reg_wr high; output stays valid across the following negedge.
REQ-017 SHALL allow push and pop in the same cycle; count unchanged; pointers wrap modulo DEPTH.
REQ-018 SHALL decide full from count before the current pop; no push while count==DEPTH even if a pop occurs.
REQ-019 SHALL preserve acceptance order of writes to the register file, including writes to the same address.
REQ-020 SHALL drive haz_hit=1 when fwd_dir!=0 and matches any valid FIFO entry or the output port while reg_wr=1.
REQ-021 SHALL drive busy = (count!=0) || reg_wr.

Reset
REQ-022 SHALL, on rst low, asynchronously clear count, pointers, reg_wr, dir_wra, di; alu_ready and mem_ready read 1 immediately.
REQ-023 SHALL discard all queued entries on reset mid-operation; no reg_wr pulse for them after release.
REQ-024 SHALL accept requests on the first posedge after rst deasserts.

Configuration
REQ-025 SHALL, with macro WB_QUEUE_FORWARD_EN defined, drive fwd_hit=haz_hit and fwd_data = data of the newest matching entry (youngest FIFO entry before output port).
REQ-026 SHALL, without WB_QUEUE_FORWARD_EN, tie fwd_hit=0 and fwd_data=0; haz_hit unaffected.

Verification
REQ-027 SHALL cover: alu push dir=3 data=32'h1234 into empty queue -> reg_wr=1, dir_wra=3, di=32'h1234 two posedges later, one cycle only.
REQ-028 SHALL cover: alu_valid and mem_valid same cycle (dir 5/6) -> mem accepted first, alu_ready=0 that cycle, writes emerge 6 then 5.
REQ-029 SHALL cover: 5 back-to-back mem pushes with DEPTH=4, no pop stall -> mem_ready low only when count==4; all 5 writes emerge in order, none lost.
REQ-030 SHALL cover: push dir=7 data=A then dir=7 data=B, fwd_dir=7 -> haz_hit=1, fwd_data=B (macro on), fwd_hit=0 (macro off).
REQ-031 SHALL cover: push dir=0 data=32'hFFFF -> handshake completes, reg_wr never pulses, busy stays 0.
REQ-032 SHALL cover: rst low with 3 entries queued -> reg_wr, busy 0 immediately; no writes after release; next push appears with 2-posedge latency.
